// File: rtl/division_pkg.sv
// Shared width constant and FSM state encoding for the restoring divider.
package division_pkg;
    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;
endpackage

// File: rtl/module_restador.sv
// Trial subtractor: combinational minuend - subtrahend, sign taken from the result MSB.
// Zero latency; no flow control.
module module_restador #(
    parameter int W = 5
) (
    input  logic [W-1:0] minuendo,
    input  logic [W-1:0] sustraendo,
    output logic [W-1:0] diferencia,
    output logic         negativo
);
    assign diferencia = minuendo - sustraendo;
    assign negativo   = diferencia[W-1];
endmodule

// File: rtl/module_divisor_control.sv
// Restoring MSB-first divider control: drives quotient-bit writes (enable/indice/~signo).
// Latency WIDTH+2 cycles from start (2 on a zero divisor); start ignored while not IDLE.
module module_divisor_control
    import division_pkg::*;
#(
    parameter int  WIDTH = division_pkg::WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             enable,
    output logic             signo,
    output logic [IDX_W-1:0] indice,
    output logic [WIDTH-1:0] residuo,
    output logic             busy,
    output logic             done,
    output logic             div_cero
);
    state_t state, state_nxt;

    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] v_q;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   s;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_nxt;
    logic [IDX_W-1:0] count;
    logic             neg;

    // Shift the next dividend bit into the partial remainder.
    assign s = (r << 1) | {{WIDTH{1'b0}}, d_q[count]};

    module_restador #(
        .W (WIDTH + 1)
    ) u_restador (
        .minuendo   (s),
        .sustraendo ({1'b0, v_q}),
        .diferencia (t),
        .negativo   (neg)
    );

    // Restore on a negative trial, otherwise keep the difference.
    assign r_nxt = neg ? s : t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = (v_q == '0) ? DONE : ITER;
            ITER:    if (count == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q      <= '0;
            v_q      <= '0;
            r        <= '0;
            count    <= '0;
            residuo  <= '0;
            div_cero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_q      <= dividendo;
                        v_q      <= divisor;
                        r        <= '0;
                        count    <= IDX_W'(WIDTH - 1);
                        div_cero <= 1'b0;
                    end
                end
                LOAD: begin
                    if (v_q == '0) begin
                        div_cero <= 1'b1;
                        residuo  <= d_q;
                    end
                end
                ITER: begin
                    r     <= r_nxt;
                    count <= count - IDX_W'(1);
                    if (count == '0) begin
                        residuo <= r_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign enable = (state == ITER);
    assign signo  = enable & neg;
    assign indice = enable ? count : '0;
    assign busy   = (state == LOAD) || (state == ITER);
    assign done   = (state == DONE);
endmodule

// File: tb/tb_module_divisor_control.sv
// Bench for module_divisor_control: scoreboard of reference quotients/remainders plus scenario tasks.
module tb_module_divisor_control;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividendo;
    logic [3:0] divisor;
    logic       enable;
    logic       signo;
    logic [1:0] indice;
    logic [3:0] residuo;
    logic       busy;
    logic       done;
    logic       div_cero;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] rem;
        logic       zero;
        logic [3:0] sig;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] qreg = 4'b0000;
    logic [3:0] tr_sig = 4'b0000;
    int         en_cnt = 0;

    module_divisor_control dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .enable    (enable),
        .signo     (signo),
        .indice    (indice),
        .residuo   (residuo),
        .busy      (busy),
        .done      (done),
        .div_cero  (div_cero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream quotient register fed by the control outputs.
    always @(posedge clk) begin
        if (enable) qreg[indice] <= ~signo;
    end

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = 4'd0; e.rem = a; e.zero = 1'b1; e.sig = 4'd0;
        end else begin
            e.q = a / b; e.rem = a % b; e.zero = 1'b0; e.sig = ~(a / b);
        end
        return e;
    endfunction

    // Scoreboard monitor: traces each ITER step and pops the expected result at done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            tr_sig = 4'd0;
            en_cnt = 0;
        end else begin
            if (enable) begin
                checks++;
                if (indice !== 2'(3 - en_cnt)) begin
                    errors++;
                    $display("FAIL indice_order: got %0d want %0d", indice, 2'(3 - en_cnt));
                end
                tr_sig[indice] = signo;
                en_cnt++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: done with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (residuo !== e.rem) begin
                        errors++;
                        $display("FAIL residuo: got %0d want %0d", residuo, e.rem);
                    end
                    checks++;
                    if (div_cero !== e.zero) begin
                        errors++;
                        $display("FAIL div_cero: got %b want %b", div_cero, e.zero);
                    end
                    checks++;
                    if (en_cnt !== (e.zero ? 0 : 4)) begin
                        errors++;
                        $display("FAIL enable_cycles: got %0d want %0d", en_cnt, (e.zero ? 0 : 4));
                    end
                    if (!e.zero) begin
                        checks++;
                        if (tr_sig !== e.sig) begin
                            errors++;
                            $display("FAIL signo_trace: got %b want %b", tr_sig, e.sig);
                        end
                        checks++;
                        if (qreg !== e.q) begin
                            errors++;
                            $display("FAIL quotient: got %b want %b", qreg, e.q);
                        end
                    end
                end
                tr_sig = 4'd0;
                en_cnt = 0;
            end
        end
    end

    task automatic launch(input logic [3:0] a, input logic [3:0] b, input bit hold);
        @(negedge clk);
        dividendo = a;
        divisor   = b;
        start     = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividendo = 4'd0; divisor = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({enable, signo, indice, residuo, busy, done, div_cero} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {enable, signo, indice, residuo, busy, done, div_cero});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int n;
        launch(4'd13, 4'd3, 1'b0);
        wait_done(1, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL latency_13_3: got %0d want 6", n);
        end
        checks++;
        if (qreg !== 4'b0100) begin
            errors++;
            $display("FAIL q_13_3: got %b want 0100", qreg);
        end
    endtask

    task automatic test_patterns;
        int n;
        launch(4'd15, 4'd1, 1'b0);
        wait_done(1, n);
        launch(4'd2, 4'd5, 1'b0);
        wait_done(1, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL latency_2_5: got %0d want 6", n);
        end
    endtask

    task automatic test_div_zero;
        int n;
        launch(4'd7, 4'd0, 1'b0);
        wait_done(1, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL latency_div_zero: got %0d want 2", n);
        end
        @(negedge clk);
        checks++;
        if ({div_cero, residuo} !== {1'b1, 4'd7}) begin
            errors++;
            $display("FAIL zero_hold: got %b want 10111", {div_cero, residuo});
        end
    endtask

    task automatic test_start_ignored;
        int n;
        launch(4'd13, 4'd3, 1'b0);
        @(negedge clk);
        start = 1'b1; dividendo = 4'd15; divisor = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL latency_ignored: got %0d want 6", n);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL spurious_op: busy got %b want 0", busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        launch(4'd13, 4'd3, 1'b1);
        wait_done(1, n);
        dividendo = 4'd9; divisor = 4'd2;
        sb.push_back(model(4'd9, 4'd2));
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy,done got %b want 00", {busy, done});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_relaunch: busy got %b want 1", busy);
        end
        start = 1'b0;
        wait_done(1, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL latency_b2b: got %0d want 6", n);
        end
    endtask

    task automatic test_reset_mid_op;
        int n;
        launch(4'd13, 4'd3, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if ({enable, signo, indice, residuo, busy, done, div_cero} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_op: got %b want 0", {enable, signo, indice, residuo, busy, done, div_cero});
        end
        @(negedge clk);
        rst = 1'b0; dividendo = 4'd9; divisor = 4'd2; start = 1'b1;
        sb.push_back(model(4'd9, 4'd2));
        @(negedge clk);
        start = 1'b0;
        wait_done(1, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL latency_after_reset: got %0d want 6", n);
        end
        checks++;
        if ({qreg, residuo} !== {4'b0100, 4'd1}) begin
            errors++;
            $display("FAIL result_9_2: got %b want 01000001", {qreg, residuo});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
